// File: rtl/output_shift_transmitter_if.sv
// Core-side valid/ready handshake bundle for output_shift_transmitter.
interface output_shift_transmitter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_i;
    logic                  valid_i;
    logic                  ready_o;
    logic                  busy_o;

    modport master (
        output data_i,
        output valid_i,
        input  ready_o,
        input  busy_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o,
        output busy_o
    );
endinterface

// File: rtl/output_shift_transmitter.sv
// Parallel-to-serial transmitter driving a 74HC595-style register (sclk/sdata/latch).
// Build option SHIFT_LSB_FIRST_EN: send bit 0 first (default sends the MSB first).
module output_shift_transmitter #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    output_shift_transmitter_if.slave bus,
    output logic                      sclk_o,
    output logic                      sdata_o,
    output logic                      latch_o
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 32'sd1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(32'sd1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 32'sd1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(32'sd1);
`ifdef SHIFT_LSB_FIRST_EN
    localparam int OUT_IDX = 0;
`else
    localparam int OUT_IDX = DATA_WIDTH - 32'sd1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SHIFT_LOW  = 2'd1,
        ST_SHIFT_HIGH = 2'd2,
        ST_LATCH      = 2'd3
    } state_t;

    state_t                state_r;
    logic [DIV_W-1:0]      div_cnt_r;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] shifted_s;
    logic                  sclk_r;
    logic                  latch_r;
    logic                  ready_r;
    logic                  busy_r;

    // Shift-register contents once the current bit has been clocked out.
    always_comb begin
`ifdef SHIFT_LSB_FIRST_EN
        shifted_s = shift_r >> 1'b1;
`else
        shifted_s = shift_r << 1'b1;
`endif
    end

    // Transfer sequencer; the bit on the pin is always shift_r[OUT_IDX], so it is a flop output.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r   <= ST_IDLE;
            div_cnt_r <= '0;
            bit_cnt_r <= '0;
            shift_r   <= '0;
            sclk_r    <= 1'b0;
            latch_r   <= 1'b0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.valid_i) begin
                        shift_r   <= bus.data_i;
                        bit_cnt_r <= '0;
                        div_cnt_r <= '0;
                        ready_r   <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_SHIFT_LOW;
                    end
                end
                ST_SHIFT_LOW: begin
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r <= '0;
                        sclk_r    <= 1'b1;
                        state_r   <= ST_SHIFT_HIGH;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_ONE;
                    end
                end
                ST_SHIFT_HIGH: begin
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r <= '0;
                        sclk_r    <= 1'b0;
                        if (bit_cnt_r == BIT_LAST) begin
                            // Clearing the register forces sdata low for the latch phase.
                            shift_r <= '0;
                            latch_r <= 1'b1;
                            state_r <= ST_LATCH;
                        end else begin
                            shift_r   <= shifted_s;
                            bit_cnt_r <= bit_cnt_r + BIT_ONE;
                            state_r   <= ST_SHIFT_LOW;
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_ONE;
                    end
                end
                ST_LATCH: begin
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r <= '0;
                        latch_r   <= 1'b0;
                        ready_r   <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_ONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    div_cnt_r <= '0;
                    bit_cnt_r <= '0;
                    shift_r   <= '0;
                    sclk_r    <= 1'b0;
                    latch_r   <= 1'b0;
                    ready_r   <= 1'b1;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign sclk_o      = sclk_r;
    assign sdata_o     = shift_r[OUT_IDX];
    assign latch_o     = latch_r;
    assign bus.ready_o = ready_r;
    assign bus.busy_o  = busy_r;
endmodule

// File: tb/tb_output_shift_transmitter.sv
// Self-checking bench for output_shift_transmitter (DATA_WIDTH=8, CLK_DIV=2).
// Honours SHIFT_LSB_FIRST_EN for the expected bit order.
module tb_output_shift_transmitter;
    localparam int W    = 8;
    localparam int D    = 2;
    localparam int BUSY = (2 * W + 1) * D;

    logic clk;
    logic reset_i;
    logic sclk;
    logic sdata;
    logic latch;
    int   checks;
    int   errors;

    output_shift_transmitter_if #(.DATA_WIDTH(W)) bus ();

    output_shift_transmitter #(.DATA_WIDTH(W), .CLK_DIV(D)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus),
        .sclk_o  (sclk),
        .sdata_o (sdata),
        .latch_o (latch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] serial;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bit sent in serial slot j for word d.
    function automatic logic bit_at(input logic [W-1:0] d, input int j);
`ifdef SHIFT_LSB_FIRST_EN
        return d[j];
`else
        return d[W-1-j];
`endif
    endfunction

    function automatic logic [W-1:0] serial_of(input logic [W-1:0] d);
        logic [W-1:0] s;
        s = '0;
        for (int j = 0; j < W; j++) s = {s[W-2:0], bit_at(d, j)};
        return s;
    endfunction

    // Expected {ready, sclk, sdata, latch} at the k-th sample after the accept edge.
    function automatic logic [3:0] model(input int k, input logic [W-1:0] d);
        int p;
        p = k / D;
        if (k >= BUSY) return 4'b1000;
        if (p >= 2 * W) return 4'b0001;
        return {1'b0, (p % 2) == 1, bit_at(d, p / 2), 1'b0};
    endfunction

    task automatic start(input logic [W-1:0] d);
        check("ready_before_accept", 32'(bus.ready_o), 32'd1);
        bus.data_i  = d;
        bus.valid_i = 1'b1;
    endtask

    // Watch one transfer from the sample after its accept edge until ready returns.
    task automatic collect(input logic [W-1:0] next_data, input logic hold_valid,
                           output logic [W-1:0] serial, output int rises,
                           output int highs, output int latches, output int busy);
        logic prev_sclk;
        int   n;
        serial = '0; rises = 0; highs = 0; latches = 0; busy = 0;
        prev_sclk = 1'b0;
        n = 0;
        @(negedge clk);
        bus.data_i = next_data;
        if (!hold_valid) bus.valid_i = 1'b0;
        while (bus.ready_o !== 1'b1 && n < 200) begin
            busy++;
            if (sclk && !prev_sclk) begin
                rises++;
                serial = {serial[W-2:0], sdata};
            end
            if (sclk) highs++;
            if (latch) latches++;
            prev_sclk = sclk;
            n++;
            @(negedge clk);
        end
        check("ready_return", 32'(bus.ready_o), 32'd1);
    endtask

    logic [W-1:0] ser_a, ser_b;
    int           r_a, r_b, h_a, h_b, l_a, l_b, b_a, b_b;

    initial begin
        checks      = 0;
        errors      = 0;
        reset_i     = 1'b1;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;

        // Asynchronous reset, checked before any clock edge.
        #2 reset_i = 1'b0;
        #1;
        check("rst_ready", 32'(bus.ready_o), 32'd1);
        check("rst_busy",  32'(bus.busy_o),  32'd0);
        check("rst_sclk",  32'(sclk),        32'd0);
        check("rst_sdata", 32'(sdata),       32'd0);
        check("rst_latch", 32'(latch),       32'd0);

`ifdef SHIFT_LSB_FIRST_EN
        vecs[0] = '{data: 8'hC4, serial: 8'h23};
        vecs[1] = '{data: 8'hFF, serial: 8'hFF};
        vecs[2] = '{data: 8'h00, serial: 8'h00};
        vecs[3] = '{data: 8'hA5, serial: 8'hA5};
        vecs[4] = '{data: 8'h01, serial: 8'h80};
        vecs[5] = '{data: 8'h3F, serial: 8'hFC};
`else
        vecs[0] = '{data: 8'hC4, serial: 8'hC4};
        vecs[1] = '{data: 8'hFF, serial: 8'hFF};
        vecs[2] = '{data: 8'h00, serial: 8'h00};
        vecs[3] = '{data: 8'hA5, serial: 8'hA5};
        vecs[4] = '{data: 8'h01, serial: 8'h01};
        vecs[5] = '{data: 8'h3F, serial: 8'h3F};
`endif

        repeat (3) @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);

        // Table of single transfers.
        for (int i = 0; i < 6; i++) begin
            start(vecs[i].data);
            collect(W'($urandom), 1'b0, ser_a, r_a, h_a, l_a, b_a);
            check("tbl_serial",  32'(ser_a), 32'(vecs[i].serial));
            check("tbl_rises",   32'(r_a),   32'(W));
            check("tbl_highs",   32'(h_a),   32'(W * D));
            check("tbl_latch",   32'(l_a),   32'(D));
            check("tbl_busy",    32'(b_a),   32'(BUSY));
        end

        // Busy ignore: 0x3F offered mid-transfer, taken on the first ready edge.
        start(8'hC4);
        collect(8'h3F, 1'b1, ser_a, r_a, h_a, l_a, b_a);
        check("ign_serial1", 32'(ser_a), 32'(serial_of(8'hC4)));
        check("ign_busy1",   32'(b_a),   32'(BUSY));
        collect(W'($urandom), 1'b0, ser_b, r_b, h_b, l_b, b_b);
        check("ign_serial2", 32'(ser_b), 32'(serial_of(8'h3F)));
        check("ign_busy2",   32'(b_b),   32'(BUSY));

        // Back-to-back with valid held high.
        @(negedge clk);
        start(8'hFF);
        collect(8'h00, 1'b1, ser_a, r_a, h_a, l_a, b_a);
        collect(W'($urandom), 1'b0, ser_b, r_b, h_b, l_b, b_b);
        check("b2b_serial1", 32'(ser_a),     32'(8'hFF));
        check("b2b_serial2", 32'(ser_b),     32'(8'h00));
        check("b2b_rises",   32'(r_a + r_b), 32'd16);
        check("b2b_latch",   32'(l_a + l_b), 32'(2 * D));
        check("b2b_gap",     32'(b_b),       32'(BUSY));

        // Reset after the third sclk rise aborts with no latch pulse.
        start(8'hC4);
        r_a = 0;
        begin
            logic prev_sclk;
            int   n;
            prev_sclk = 1'b0;
            n = 0;
            @(posedge clk);
            while (r_a < 3 && n < 100) begin
                @(negedge clk);
                bus.valid_i = 1'b0;
                if (sclk && !prev_sclk) r_a++;
                prev_sclk = sclk;
                n++;
            end
        end
        check("mid_rises", 32'(r_a), 32'd3);
        #2 reset_i = 1'b0;
        #1;
        check("mid_ready", 32'(bus.ready_o), 32'd1);
        check("mid_busy",  32'(bus.busy_o),  32'd0);
        check("mid_sclk",  32'(sclk),        32'd0);
        check("mid_sdata", 32'(sdata),       32'd0);
        check("mid_latch", 32'(latch),       32'd0);
        l_a = 0;
        repeat (4) begin
            @(negedge clk);
            if (latch) l_a++;
        end
        check("mid_no_latch", 32'(l_a), 32'd0);
        reset_i = 1'b1;
        @(negedge clk);
        start(8'hA5);
        collect(W'($urandom), 1'b0, ser_a, r_a, h_a, l_a, b_a);
        check("post_serial", 32'(ser_a), 32'(serial_of(8'hA5)));
        check("post_rises",  32'(r_a),   32'(W));
        check("post_latch",  32'(l_a),   32'(D));
        check("post_busy",   32'(b_a),   32'(BUSY));

        // Random words and gaps, cycle-exact against the reference model.
        for (int t = 0; t < 24; t++) begin
            logic [W-1:0] d;
            logic [3:0]   exp_pins;
            int           gap;
            d   = W'($urandom);
            gap = $urandom_range(0, 3);
            start(d);
            @(posedge clk);
            for (int k = 0; k <= BUSY; k++) begin
                @(negedge clk);
                exp_pins = model(k, d);
                check("rand_pins", 32'({bus.ready_o, sclk, sdata, latch}), 32'(exp_pins));
                check("rand_busy", 32'(bus.busy_o), 32'(!exp_pins[3]));
                if (k < BUSY - 1) begin
                    bus.valid_i = 1'($urandom);
                    bus.data_i  = W'($urandom);
                end else begin
                    bus.valid_i = 1'b0;
                end
            end
            repeat (gap) begin
                @(negedge clk);
                check("rand_idle", 32'({bus.ready_o, sclk, sdata, latch}), 32'(4'b1000));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/output_shift_transmitter.md
# output_shift_transmitter

Output-side counterpart to the input synchronizer path: converts a parallel word from the CPU core into a clocked serial stream for an external 74HC595-style shift register (serial clock, serial data, latch strobe). Sits between the core's output port logic and the chip output pins. Uses a valid/ready handshake on the core side. All pin outputs are registered, so they are glitch-free.

## Interface
- DATA_WIDTH, 8, bits per transfer (≥1)
- CLK_DIV, 4, system cycles per sclk half-period (≥1)

- clk_i  input  1  system clock, rising edge
- reset_i  input  1  asynchronous active-low reset
- data_i  input  DATA_WIDTH  word to transmit; sampled on handshake
- valid_i  input  1  core requests transfer of data_i
- ready_o  output  1  block idle; transfer accepted on rising edge when valid_i && ready_o
- busy_o  output  1  transfer in progress (inverse of ready_o)
- sclk_o  output  1  serial clock to external register; receiver samples on rising edge
- sdata_o  output  1  serial data
- latch_o  output  1  storage-register strobe, high for CLK_DIV cycles after last bit

## Operation
- States: IDLE, SHIFT_LOW, SHIFT_HIGH, LATCH.
- Reset (reset_i=0, async): state=IDLE, ready_o=1, busy_o=0, sclk_o=0, sdata_o=0, latch_o=0, counters cleared.
- IDLE: on the edge with valid_i=1, capture data_i into the shift register, clear the bit counter, go to SHIFT_LOW, and drive sdata_o with the first bit. ready_o falls on that same edge.
- SHIFT_LOW: sclk_o=0 for CLK_DIV cycles, then go to SHIFT_HIGH.
- SHIFT_HIGH: sclk_o=1 for CLK_DIV cycles. sdata_o stays stable for the whole high phase.
  - If bits remain: shift, present the next bit, increment the bit counter, go to SHIFT_LOW.
  - After bit DATA_WIDTH-1: go to LATCH.
- LATCH: sclk_o=0, sdata_o=0, latch_o=1 for CLK_DIV cycles, then IDLE with ready_o=1.
- Divider counter: width clog2(CLK_DIV), or 1 if CLK_DIV=1. It reloads on every state change.
- Bit counter: width clog2(DATA_WIDTH), or 1 if DATA_WIDTH=1.
- valid_i and data_i are ignored while busy; no queuing. A request is never lost or duplicated; the core holds valid_i until it sees ready_o.
- Reset mid-transfer aborts immediately: no latch pulse, and outputs take their reset values.

## Timing
- Accept edge to first sclk_o rise: CLK_DIV cycles.
- Busy duration: (2·DATA_WIDTH + 1)·CLK_DIV cycles from the accept edge to ready_o=1.
- Back-to-back: if valid_i=1 in the first cycle ready_o=1, that edge accepts. Minimum ready_o high time is 1 cycle.
- Setup/hold at the receiver: sdata_o changes only at a falling sclk_o edge or on entering SHIFT_LOW, so it is stable CLK_DIV cycles on each side of the rising edge.
- latch_o rises CLK_DIV cycles after the final sclk_o rise, on the same edge sclk_o falls.

## Configuration
- SHIFT_LSB_FIRST_EN defined: bit 0 is transmitted first and the shift register shifts right.
- SHIFT_LSB_FIRST_EN undefined (default): bit DATA_WIDTH-1 is transmitted first and the shift register shifts left.
- Timing and handshake are identical in both builds.

## Test plan
All scenarios use DATA_WIDTH=8, CLK_DIV=2.
- Reset: reset_i=0 → ready_o=1, busy_o=0, sclk_o=sdata_o=latch_o=0 immediately, without waiting for a clock edge.
- Single transfer, default build: data_i=0xC4, valid_i pulsed 1 cycle → sdata_o sampled at the 8 sclk_o rises = 1,1,0,0,0,1,0,0; 8 sclk pulses, each 2 high / 2 low; latch_o high 2 cycles; ready_o returns exactly 34 cycles after the accept edge.
- LSB-first build, SHIFT_LSB_FIRST_EN defined: data_i=0xC4 → sampled bits 0,0,1,0,0,0,1,1.
- Busy ignore: accept 0xC4, then drive valid_i=1 with data_i=0x3F mid-transfer → 0xC4 is shifted unchanged; 0x3F is accepted only on the first ready_o=1 edge.
- Back-to-back: valid_i held high with 0xFF, then 0x00 → two transfers with ready_o high exactly 1 cycle between them; 16 sclk pulses and 2 latch pulses total.
- Reset mid-transfer: assert reset_i=0 after the 3rd sclk rise → no latch_o pulse; all outputs at reset values; the next transfer of 0xA5 completes normally.
